mfp_uart_transmitter: RTL and testbench
=======================================

# mfp_uart_transmitter

Serial transmitter that drives the board-level `UART_TX` pin, complementing the existing UART receiver on `UART_RX`. It accepts bytes from the system side through a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized LSB-first as an asynchronous frame: start bit, 8 data bits, optional even-parity bit, 1 stop bit. It sits inside `mfp_system` next to the receiver and is clocked by the system clock.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s. The bit period is `DIV = CLK_FREQ / BAUD`, using integer truncation (434 at the defaults).
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of 2 and ≥2.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tx_data` input 8: byte to transmit.
- `tx_valid` input 1: `tx_data` is valid this cycle.
- `tx_ready` output 1: the FIFO can accept a byte (FIFO not full).
- `busy` output 1: the FIFO is non-empty or a frame is in progress.
- `tx` output 1: serial line output. Idle level is 1.

## Operation
- Push: the FIFO is written on a rising edge where `tx_valid && tx_ready`.
  - `tx_data` is ignored when `tx_ready` is 0.
  - There is no bypass path: every byte passes through the FIFO.
- `tx_ready = !full`.
  - When the FIFO is full, a push is refused even if a pop happens on the same edge.
  - A push and a pop on the same edge when the FIFO is not full are both performed, and the occupancy is unchanged.
- FSM states and transitions:
  - IDLE → START, when the FIFO is non-empty. On this edge the FSM pops the head byte into the shift register.
  - START → DATA.
  - DATA → DATA for 8 bits, LSB first. After bit 7 → PARITY if parity is enabled, otherwise → STOP.
  - PARITY → STOP.
  - STOP → START if the FIFO is non-empty (pops on the same edge). Otherwise → IDLE.
- Every non-IDLE state holds `tx` for exactly `DIV` cycles.
  - A bit counter of width `$clog2(DIV)` counts 0..DIV-1.
  - The state or bit advances on the edge where the counter equals DIV-1, and the counter wraps to 0.
- `tx` is a registered output:
  - 1 in IDLE and STOP.
  - 0 in START.
  - the current data bit in DATA.
  - the parity bit in PARITY.
- `busy = (state != IDLE) || !empty`.
- Reset, including mid-frame:
  - `tx` = 1, `tx_ready` = 1, `busy` = 0.
  - FIFO pointers are cleared, the FSM goes to IDLE, the counters go to 0.
  - Any partially sent frame is aborted and buffered bytes are discarded.
- Elaboration error if `DIV < 2`.

## Timing
- Latency: a byte pushed on edge N with the FSM idle produces `tx` = 0 from edge N+2, after the FIFO write at N and the pop/load at N+1.
- Frame length is exactly 10×DIV cycles, or 11×DIV with parity.
- Back-to-back frames have zero idle cycles. The next start bit begins on the edge that ends the previous stop bit.
- `tx_ready` falls on the edge that makes the FIFO full. It rises on the edge of the pop that frees a slot.
- `busy` falls on the edge that ends the last stop bit when the FIFO is empty.

## Configuration
- Macro: `MFP_UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in.
  - The bit sent is the even parity of the 8 data bits (XOR of `tx_data`), so the total count of ones in data plus parity is even.
  - Frame is 11×DIV cycles.
- Undefined:
  - The PARITY state and its logic are absent.
  - Frame is 8N1, 10×DIV cycles.

## Test plan
Bench settings: `CLK_FREQ`=1_000_000, `BAUD`=100_000, so DIV = 10.

- Single byte: push 0x55 into an idle block.
  - `tx` = 0 from edge N+2 for 10 cycles.
  - Then 1,0,1,0,1,0,1,0, each for 10 cycles.
  - Then stop = 1 for 10 cycles.
  - `busy` is 0 exactly 100 cycles after the start bit begins (110 with parity).
- Parity (macro defined):
  - 0x55 → parity bit 0.
  - 0x01 → parity bit 1.
  - 0x01 frame: start 0, data 1,0,0,0,0,0,0,0, parity 1, stop 1. Total 110 cycles.
- FIFO full: push 5 bytes 0xA0..0xA4 on consecutive cycles from idle.
  - 0xA0 is popped and 0xA1..0xA4 fill the FIFO, so `tx_ready` = 0.
  - A further push of 0xFF is refused.
  - The wire carries exactly 0xA0..0xA4 in order, with no gaps between frames.
- Back-to-back: push 0x00 then 0xFF.
  - The second start bit begins on the edge ending the first stop bit.
  - `tx` is never high for more than 10 cycles between the two frames.
- Reset mid-frame: assert `reset` asynchronously during data bit 3 with 2 bytes queued.
  - `tx` = 1, `tx_ready` = 1, `busy` = 0 before the next clock edge.
  - After deassertion, `tx` stays 1 for 200 cycles with no pushes.
- Same-edge push/pop: FIFO holds 3 bytes; push on the edge where STOP→START pops.
  - Occupancy stays at 3.
  - `tx_ready` stays 1.

Source files
------------

// File: rtl/mfp_uart_transmitter.sv
// Buffered UART transmitter: byte FIFO feeding an 8-bit LSB-first async framer.
// Define MFP_UART_TX_PARITY_EN to insert an even-parity bit (8E1); default is 8N1.
module mfp_uart_transmitter #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("mfp_uart_transmitter: CLK_FREQ / BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mfp_uart_transmitter: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

`ifdef MFP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        tx_q;
  logic        cnt_last;
`ifdef MFP_UART_TX_PARITY_EN
  logic        par_q;
`endif

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = tx_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign cnt_last = (cnt_q == CW'(DIV - 1));
  assign pop      = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_last));

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  assign tx_ready = !full;
  assign busy     = (state_q != S_IDLE) || !empty;
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // tx is re-registered from the current state, so the wire trails the FSM by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= sh_q[0];
`ifdef MFP_UART_TX_PARITY_EN
        S_PARITY: tx_q <= par_q;
`endif
        default:  tx_q <= 1'b1;
      endcase

      if (state_q != S_IDLE) begin
        cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
      end

      if (pop) begin
        sh_q    <= head;
`ifdef MFP_UART_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end

      case (state_q)
        S_IDLE: begin
          if (pop) state_q <= S_START;
        end
        S_START: begin
          if (cnt_last) begin
            state_q <= S_DATA;
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (cnt_last) begin
            if (bit_q == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end
        end
`ifdef MFP_UART_TX_PARITY_EN
        S_PARITY: begin
          if (cnt_last) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (cnt_last) state_q <= pop ? S_START : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Self-checking bench for mfp_uart_transmitter at DIV = 10; a line monitor decodes
// frames and the main sequence compares them with a queue of accepted bytes.
module tb_mfp_uart_transmitter;

  localparam int DIV = 10;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = DIV * NB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_push = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_data[$];
  int         rx_start[$];
  logic       rx_ok[$];
  logic       rx_par[$];

  logic       mon_busy = 1'b0;
  logic       m_v, m_p, m_good, m_abort;
  logic [7:0] m_d;
  int         m_st;

  mfp_uart_transmitter #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: every bit window must hold one level for exactly DIV samples.
  always begin : monitor
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      mon_busy = 1'b1;
      m_st = cyc; m_good = 1'b1; m_abort = 1'b0; m_d = '0; m_p = 1'b0; m_v = 1'b0;
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < DIV; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (reset !== 1'b0) m_abort = 1'b1;
          if (k == 0) m_v = tx;
          else if (tx !== m_v) m_good = 1'b0;
        end
        if (b == 0) begin
          if (m_v !== 1'b0) m_good = 1'b0;
        end else if (b <= 8) begin
          m_d[b-1] = m_v;
        end else if (b == NB - 1) begin
          if (m_v !== 1'b1) m_good = 1'b0;
        end else begin
          m_p = m_v;
        end
      end
      if (!m_abort) begin
        rx_data.push_back(m_d);
        rx_start.push_back(m_st);
        rx_ok.push_back(m_good);
        rx_par.push_back(m_p);
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; the push lands on the next rising edge.
  task automatic push(input logic [7:0] b, input logic exp_rdy);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("tx_ready_at_push", {31'd0, tx_ready}, {31'd0, exp_rdy});
    if (exp_rdy) exp_q.push_back(b);
    @(posedge clk); #1;
    last_push = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic push_flow(input logic [7:0] b);
    int w;
    w = 0;
    tx_data = b;
    @(negedge clk);
    while (tx_ready !== 1'b1 && w < 4 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("flow_ready_wait", {31'd0, (w < 4 * FRAME)}, 32'd1);
    tx_valid = 1'b1;
    exp_q.push_back(b);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_neg_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_post_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || mon_busy) && w < 30 * FRAME) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_drain_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic compare_frames(input string tag, input logic b2b);
    int d;
    chk({tag, "_frame_count"}, rx_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      chk({tag, "_data"}, {24'd0, rx_data[i]}, {24'd0, exp_q[i]});
      chk({tag, "_frame_shape"}, {31'd0, rx_ok[i]}, 32'd1);
`ifdef MFP_UART_TX_PARITY_EN
      chk({tag, "_parity"}, {31'd0, rx_par[i]}, $countones(exp_q[i]) % 2);
`endif
      if (i > 0) begin
        d = rx_start[i] - rx_start[i-1];
        if (b2b) chk({tag, "_gap"}, d, FRAME);
        else     chk({tag, "_spacing"}, {31'd0, (d >= FRAME)}, 32'd1);
      end
    end
    exp_q.delete(); rx_data.delete(); rx_start.delete(); rx_ok.delete(); rx_par.delete();
  endtask

  initial begin : main
    int n0, st, hi, gap;
    logic [7:0] rb;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single byte: latency, busy timing, waveform
    push(8'h55, 1'b1);
    n0 = last_push;
    st = n0 + 2;
    wait_neg_cyc(st + FRAME - 2);
    chk("single_busy_late", {31'd0, busy}, 32'd1);
    wait_neg_cyc(st + FRAME);
    chk("single_busy_done", {31'd0, busy}, 32'd0);
    wait_idle("single");
    chk("single_latency", rx_start.size() > 0 ? rx_start[0] : -1, st);
    compare_frames("single55", 1'b0);

    push(8'h01, 1'b1);
    wait_idle("single01");
    compare_frames("single01", 1'b0);

    // FIFO full: A0 popped, A1..A4 fill, FF refused
    for (int i = 0; i < 5; i++) begin
      push(8'hA0 + 8'(i), 1'b1);
      if (i == 0) n0 = last_push;
    end
    push(8'hFF, 1'b0);
    wait_idle("full");
    chk("full_latency", rx_start.size() > 0 ? rx_start[0] : -1, n0 + 2);
    compare_frames("full", 1'b1);

    // Back-to-back
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_idle("b2b");
    compare_frames("b2b", 1'b1);

    // Asynchronous reset during data bit 3 with two bytes queued
    push(8'hC3, 1'b1);
    n0 = last_push;
    push(8'h5A, 1'b1);
    push(8'hA5, 1'b1);
    wait_neg_cyc(n0 + 2 + DIV * 4 + 5);
    chk("prereset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_tx", {31'd0, tx}, 32'd1);
    chk("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    chk("postreset_idle_line", hi, 200);
    chk("postreset_busy", {31'd0, busy}, 32'd0);
    chk("postreset_no_frames", rx_data.size(), 0);
    rx_data.delete(); rx_start.delete(); rx_ok.delete(); rx_par.delete();
    @(posedge clk); #1;

    // Same-edge push and pop with three bytes buffered
    push(8'h11, 1'b1);
    n0 = last_push;
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    wait_post_cyc(n0 + FRAME);
    push(8'h55, 1'b1);
    push(8'h66, 1'b1);
    push(8'h77, 1'b0);
    wait_idle("samedge");
    compare_frames("samedge", 1'b1);

    // Random bytes with random idle gaps
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, FRAME + FRAME / 2));
      repeat (gap) @(posedge clk);
      #1;
      rb = 8'($urandom_range(0, 255));
      push_flow(rb);
    end
    wait_idle("random");
    compare_frames("random", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
